// File: rtl/lsu_pkg.sv
// Shared constants and helpers for the load/store unit.
// Covers funct3 decode, FSM encoding and store lane formatting.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_WB     = 2'd2;

  // Misaligned and illegal encodings share one rejection path
  function automatic logic op_reject(
    input logic       load,
    input logic [2:0] f3,
    input logic [1:0] off
  );
    logic r;
    r = 1'b1;
    case (f3)
      F3_B:    r = 1'b0;
      F3_H:    r = off[0];
      F3_W:    r = (off != 2'b00);
      F3_BU:   r = !load;
      F3_HU:   r = !load || off[0];
      default: r = 1'b1;
    endcase
    return r;
  endfunction

  function automatic logic [3:0] be_of(
    input logic [2:0] f3,
    input logic [1:0] off
  );
    logic [3:0] be;
    case (f3[1:0])
      2'b00:   be = 4'b0001 << off;
      2'b01:   be = 4'b0011 << off;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

  function automatic logic [31:0] wdata_of(
    input logic [2:0]  f3,
    input logic [31:0] d
  );
    logic [31:0] w;
    case (f3[1:0])
      2'b00:   w = {4{d[7:0]}};
      2'b01:   w = {2{d[15:0]}};
      default: w = d;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Load data lane select and sign/zero extension.
// Purely combinational; offset picks the byte or half lane.
module lsu_load_align
  import lsu_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  offset,
  input  logic [2:0]  funct3,
  output logic [31:0] data
);

  logic [31:0] sh;

  assign sh = rdata >> {offset, 3'b000};

  always_comb begin
    data = rdata;
    case (funct3)
      F3_B:    data = {{24{sh[7]}}, sh[7:0]};
      F3_BU:   data = {24'b0, sh[7:0]};
      F3_H:    data = {{16{sh[15]}}, sh[15:0]};
      F3_HU:   data = {16'b0, sh[15:0]};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// Load/store unit: one op at a time from execute onto a
// single-outstanding req/ack bus, with load writeback.
module lsu
  import lsu_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_load,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [4:0]  req_rd,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        w_en,
  output logic [4:0]  w_addr,
  output logic [31:0] w_data,
  output logic        misalign,
  output logic        bus_err
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TO_V = CW'(TIMEOUT);

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
  logic          load_q, load_d;
  logic [2:0]    f3_q, f3_d;
  logic [1:0]    off_q, off_d;
  logic [4:0]    rd_q, rd_d;
  logic          mem_req_q, mem_req_d;
  logic          mem_we_q, mem_we_d;
  logic [31:0]   mem_addr_q, mem_addr_d;
  logic [3:0]    mem_be_q, mem_be_d;
  logic [31:0]   mem_wdata_q, mem_wdata_d;
  logic [4:0]    w_addr_q, w_addr_d;
  logic [31:0]   w_data_q, w_data_d;
  logic          mis_q, mis_d;
  logic          berr_q, berr_d;
  logic [31:0]   ld_data;

  lsu_load_align u_align (
    .rdata  (mem_rdata),
    .offset (off_q),
    .funct3 (f3_q),
    .data   (ld_data)
  );

  assign cnt_inc = cnt_q + 1'b1;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    load_d      = load_q;
    f3_d        = f3_q;
    off_d       = off_q;
    rd_d        = rd_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_be_d    = mem_be_q;
    mem_wdata_d = mem_wdata_q;
    w_addr_d    = w_addr_q;
    w_data_d    = w_data_q;
    mis_d       = 1'b0;
    berr_d      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          if (op_reject(req_load, req_funct3, req_addr[1:0])) begin
            mis_d = 1'b1;
          end else begin
            state_d     = ST_ACCESS;
            cnt_d       = '0;
            load_d      = req_load;
            f3_d        = req_funct3;
            off_d       = req_addr[1:0];
            rd_d        = req_rd;
            mem_req_d   = 1'b1;
            mem_we_d    = !req_load;
            mem_addr_d  = {req_addr[31:2], 2'b00};
            mem_be_d    = req_load ? 4'b0000
                        : be_of(req_funct3, req_addr[1:0]);
            mem_wdata_d = req_load ? 32'h0
                        : wdata_of(req_funct3, req_wdata);
          end
        end
      end
      ST_ACCESS: begin
        if (mem_ack) begin
          mem_req_d = 1'b0;
          if (load_q) begin
            state_d = ST_WB;
            if (rd_q != 5'd0) begin
              w_addr_d = rd_q;
              w_data_d = ld_data;
            end
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          cnt_d = cnt_inc;
          if (cnt_inc == TO_V) begin
            berr_d    = 1'b1;
            mem_req_d = 1'b0;
            state_d   = ST_IDLE;
          end
        end
      end
      ST_WB:   state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      load_q      <= 1'b0;
      f3_q        <= 3'b0;
      off_q       <= 2'b0;
      rd_q        <= 5'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= 32'h0;
      mem_be_q    <= 4'b0;
      mem_wdata_q <= 32'h0;
      w_addr_q    <= 5'b0;
      w_data_q    <= 32'h0;
      mis_q       <= 1'b0;
      berr_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      load_q      <= load_d;
      f3_q        <= f3_d;
      off_q       <= off_d;
      rd_q        <= rd_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_be_q    <= mem_be_d;
      mem_wdata_q <= mem_wdata_d;
      w_addr_q    <= w_addr_d;
      w_data_q    <= w_data_d;
      mis_q       <= mis_d;
      berr_q      <= berr_d;
    end
  end

  assign req_ready = (state_q == ST_IDLE);
  assign w_en      = (state_q == ST_WB) && (rd_q != 5'd0);
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_be    = mem_be_q;
  assign mem_wdata = mem_wdata_q;
  assign w_addr    = w_addr_q;
  assign w_data    = w_data_q;
  assign misalign  = mis_q;
  assign bus_err   = berr_q;

endmodule

// File: tb/tb_lsu.sv
// Directed vector bench for the load/store unit.
// Table of ops plus a hand-written reset-mid-access sequence.
module tb_lsu;
  import lsu_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_load = 1'b0;
  logic [2:0]  req_funct3 = 3'b0;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic [4:0]  req_rd = 5'h0;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = 32'h0;
  logic        w_en;
  logic [4:0]  w_addr;
  logic [31:0] w_data;
  logic        misalign, bus_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  lsu #(.TIMEOUT(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_load   (req_load),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_rd     (req_rd),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_be     (mem_be),
    .mem_wdata  (mem_wdata),
    .mem_ack    (mem_ack),
    .mem_rdata  (mem_rdata),
    .w_en       (w_en),
    .w_addr     (w_addr),
    .w_data     (w_data),
    .misalign   (misalign),
    .bus_err    (bus_err)
  );

  typedef struct {
    logic        ld;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [4:0]  rd;
    int          ack;
    logic [31:0] e_addr;
    logic [3:0]  e_be;
    logic [31:0] e_wd;
    int          e_req;
    int          e_wen;
    logic [31:0] e_rf;
    int          e_mis;
    int          e_berr;
    int          e_rdy;
  } vec_t;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  be;
    logic        we;
    logic [31:0] wd;
    int          req;
    int          unstable;
    int          wen;
    logic [4:0]  waddr;
    logic [31:0] rf;
    int          mis;
    int          berr;
    int          rdy;
  } obs_t;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask

  task automatic run(input vec_t v, output obs_t o);
    o = '{addr: 0, be: 0, we: 0, wd: 0, req: 0, unstable: 0,
          wen: 0, waddr: 0, rf: 0, mis: 0, berr: 0, rdy: 0};
    @(negedge clk);
    req_valid  = 1'b1;
    req_load   = v.ld;
    req_funct3 = v.f3;
    req_addr   = v.addr;
    req_wdata  = v.wdata;
    req_rd     = v.rd;
    @(negedge clk);
    req_valid = 1'b0;
    for (int i = 1; i <= 30; i++) begin
      if (mem_req) begin
        o.req++;
        if (o.req == 1) begin
          o.addr = mem_addr;
          o.be   = mem_be;
          o.we   = mem_we;
          o.wd   = mem_wdata;
        end else if (mem_addr !== o.addr || mem_be !== o.be ||
                     mem_we !== o.we || mem_wdata !== o.wd) begin
          o.unstable++;
        end
      end
      if (w_en) begin
        o.wen++;
        o.waddr = w_addr;
        o.rf    = w_data;
      end
      if (misalign) o.mis++;
      if (bus_err) o.berr++;
      if (req_ready) begin
        o.rdy = i;
        break;
      end
      mem_ack   = mem_req && (v.ack != 0) && (o.req == v.ack);
      mem_rdata = mem_ack ? v.rdata : 32'h0;
      @(negedge clk);
    end
    mem_ack   = 1'b0;
    mem_rdata = 32'h0;
  endtask

  vec_t vt[16];

  function automatic vec_t mk(
    input logic ld, input logic [2:0] f3, input logic [31:0] addr,
    input logic [31:0] wdata, input logic [31:0] rdata,
    input logic [4:0] rd, input int ack, input logic [31:0] e_addr,
    input logic [3:0] e_be, input logic [31:0] e_wd, input int e_req,
    input int e_wen, input logic [31:0] e_rf, input int e_mis,
    input int e_berr, input int e_rdy);
    vec_t v;
    v = '{ld, f3, addr, wdata, rdata, rd, ack, e_addr, e_be, e_wd,
          e_req, e_wen, e_rf, e_mis, e_berr, e_rdy};
    return v;
  endfunction

  initial begin
    obs_t o;
    int wc;
    int rc;

    vt[0]  = mk(1, F3_B,  32'h1003, 0, 32'h80FF1234, 5, 2,
                32'h1000, 4'b0000, 0, 2, 1, 32'hFFFFFF80, 0, 0, 4);
    vt[1]  = mk(1, F3_HU, 32'h2002, 0, 32'h9ABC5678, 6, 1,
                32'h2000, 4'b0000, 0, 1, 1, 32'h00009ABC, 0, 0, 3);
    vt[2]  = mk(1, F3_H,  32'h2002, 0, 32'h9ABC5678, 7, 3,
                32'h2000, 4'b0000, 0, 3, 1, 32'hFFFF9ABC, 0, 0, 5);
    vt[3]  = mk(0, F3_B,  32'h3001, 32'h112233AB, 0, 0, 2,
                32'h3000, 4'b0010, 32'hABABABAB, 2, 0, 0, 0, 0, 3);
    vt[4]  = mk(1, F3_W,  32'h4002, 0, 0, 4, 1,
                0, 0, 0, 0, 0, 0, 1, 0, 1);
    vt[5]  = mk(1, F3_W,  32'h4000, 0, 32'h12345678, 0, 1,
                32'h4000, 4'b0000, 0, 1, 0, 0, 0, 0, 3);
    vt[6]  = mk(0, F3_H,  32'h5002, 32'hAABBCCDD, 0, 0, 1,
                32'h5000, 4'b1100, 32'hCCDDCCDD, 1, 0, 0, 0, 0, 2);
    vt[7]  = mk(0, F3_W,  32'h6000, 32'hDEADBEEF, 0, 0, 4,
                32'h6000, 4'b1111, 32'hDEADBEEF, 4, 0, 0, 0, 0, 5);
    vt[8]  = mk(1, F3_BU, 32'h7001, 0, 32'h11228344, 9, 1,
                32'h7000, 4'b0000, 0, 1, 1, 32'h00000083, 0, 0, 3);
    vt[9]  = mk(1, F3_W,  32'h8000, 0, 32'hCAFEF00D, 31, 1,
                32'h8000, 4'b0000, 0, 1, 1, 32'hCAFEF00D, 0, 0, 3);
    vt[10] = mk(1, F3_H,  32'h9001, 0, 0, 3, 1,
                0, 0, 0, 0, 0, 0, 1, 0, 1);
    vt[11] = mk(1, 3'b011, 32'hA000, 0, 0, 3, 1,
                0, 0, 0, 0, 0, 0, 1, 0, 1);
    vt[12] = mk(0, F3_BU, 32'hB000, 32'h55, 0, 0, 1,
                0, 0, 0, 0, 0, 0, 1, 0, 1);
    vt[13] = mk(1, F3_W,  32'hC000, 0, 32'h0, 10, 0,
                32'hC000, 4'b0000, 0, 4, 0, 0, 0, 1, 5);
    vt[14] = mk(1, F3_B,  32'h1000, 0, 32'h1234567F, 1, 1,
                32'h1000, 4'b0000, 0, 1, 1, 32'h0000007F, 0, 0, 3);
    vt[15] = mk(1, F3_HU, 32'h2000, 0, 32'h8001FFFE, 2, 2,
                32'h2000, 4'b0000, 0, 2, 1, 32'h0000FFFE, 0, 0, 4);

    #12;
    chk("rst_ready", {31'b0, req_ready}, 1);
    chk("rst_mem_req", {31'b0, mem_req}, 0);
    chk("rst_w_en", {31'b0, w_en}, 0);
    chk("rst_flags", {30'b0, misalign, bus_err}, 0);
    chk("rst_mem_addr", mem_addr, 0);
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < 16; i++) begin
      run(vt[i], o);
      chk($sformatf("v%0d_req", i), o.req, vt[i].e_req);
      chk($sformatf("v%0d_wen", i), o.wen, vt[i].e_wen);
      chk($sformatf("v%0d_mis", i), o.mis, vt[i].e_mis);
      chk($sformatf("v%0d_berr", i), o.berr, vt[i].e_berr);
      chk($sformatf("v%0d_rdy", i), o.rdy, vt[i].e_rdy);
      if (vt[i].e_req != 0) begin
        chk($sformatf("v%0d_addr", i), o.addr, vt[i].e_addr);
        chk($sformatf("v%0d_be", i), {28'b0, o.be}, {28'b0, vt[i].e_be});
        chk($sformatf("v%0d_we", i), {31'b0, o.we}, {31'b0, !vt[i].ld});
        chk($sformatf("v%0d_stable", i), o.unstable, 0);
        if (!vt[i].ld)
          chk($sformatf("v%0d_wdata", i), o.wd, vt[i].e_wd);
      end
      if (vt[i].e_wen != 0) begin
        chk($sformatf("v%0d_waddr", i), {27'b0, o.waddr},
            {27'b0, vt[i].rd});
        chk($sformatf("v%0d_rf", i), o.rf, vt[i].e_rf);
      end
    end

    // reset dropped while a load is waiting on the bus
    @(negedge clk);
    req_valid  = 1'b1;
    req_load   = 1'b1;
    req_funct3 = F3_W;
    req_addr   = 32'h4000;
    req_rd     = 5'd3;
    @(negedge clk);
    req_valid = 1'b0;
    chk("mid_mem_req", {31'b0, mem_req}, 1);
    #2 reset = 1'b0;
    #1;
    chk("async_mem_req", {31'b0, mem_req}, 0);
    chk("async_ready", {31'b0, req_ready}, 1);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    mem_ack   = 1'b1;
    mem_rdata = 32'hFFFFFFFF;
    @(negedge clk);
    mem_ack   = 1'b0;
    mem_rdata = 32'h0;
    wc = 0;
    rc = 0;
    for (int i = 0; i < 3; i++) begin
      if (w_en) wc++;
      if (req_ready) rc++;
      @(negedge clk);
    end
    chk("late_ack_wen", wc, 0);
    chk("late_ack_ready", rc, 3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
